// File: rtl/fast_frame_sequencer.sv
// Generic synchronous FIFO with registered pointers and an occupancy count.
// Latency: a written entry is visible at rd_dat the cycle after the write.
// Backpressure: wr_rdy drops when full unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign rd_vld = (count != '0);
    assign rd_acc = rd_vld & rd_rdy;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_rdy = (count != (AW+1)'(DEPTH)) | rd_acc;
    assign wr_acc = wr_vld & wr_rdy;
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Frame sequencer: feeds FAST_with_NMS one pixel per ce, drains it with flush cycles, queues corners.
// Latency: fast_ce/fast_data one cycle after the pixel handshake; corners visible one cycle after corner_in.
// Backpressure: pixel ready and flush ce stall while the corner FIFO is within two entries of full.
module fast_frame_sequencer #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int PIXEL_WIDTH = 8,
    parameter int FLUSH_LINES = 6,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    input  logic [PIXEL_WIDTH-1:0] s_pix_data,
    input  logic                   s_pix_valid,
    output logic                   s_pix_ready,
    output logic                   fast_ce,
    output logic [PIXEL_WIDTH-1:0] fast_data,
    input  logic                   corner_in,
    input  logic [9:0]             x_in,
    input  logic [9:0]             y_in,
    output logic                   m_corner_valid,
    input  logic                   m_corner_ready,
    output logic [9:0]             m_corner_x,
    output logic [9:0]             m_corner_y,
    output logic [15:0]            corner_count,
    output logic                   overflow
);
    localparam int FLUSH_CYC = FLUSH_LINES * COL_NUM;
    localparam int COL_W     = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
    localparam int ROW_W     = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int FL_W      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COL_NUM - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROW_NUM - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] STALL_LVL  = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [FL_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_wr_rdy;
    logic             stall;
    logic             pix_hs;
    logic             flush_ce;
    logic             last_pix;
    logic             last_flush;
    logic             frame_start;
    logic             done_now;
    logic             push_acc;
    logic             push_drop;

    // Two-entry margin absorbs corners already inside the core when ce stops.
    assign stall       = (fifo_count >= STALL_LVL);
    assign s_pix_ready = (state == RUN) & ~stall;
    assign pix_hs      = s_pix_valid & s_pix_ready;
    assign flush_ce    = (state == FLUSH) & ~stall;
    assign last_pix    = (col == COL_LAST) & (row == ROW_LAST);
    assign last_flush  = (flush_cnt == FLUSH_LAST);
    assign busy        = (state != IDLE);
    assign push_acc    = corner_in & fifo_wr_rdy;
    assign push_drop   = corner_in & ~fifo_wr_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        done_now    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                if (pix_hs && last_pix) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_ce && last_flush) state_nxt = DONE;
            end
            DONE: begin
                if (!m_corner_valid) begin
                    state_nxt = IDLE;
                    done_now  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            flush_cnt  <= '0;
            fast_ce    <= 1'b0;
            fast_data  <= '0;
            frame_done <= 1'b0;
        end else begin
            fast_ce    <= pix_hs | flush_ce;
            frame_done <= done_now;
            if (pix_hs)              fast_data <= s_pix_data;
            else if (state == FLUSH) fast_data <= '0;

            if (frame_start) begin
                col       <= '0;
                row       <= '0;
                flush_cnt <= '0;
            end else begin
                if (pix_hs) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                if (flush_ce) flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // A corner arriving on the start cycle belongs to the new frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corner_count <= '0;
            overflow     <= 1'b0;
        end else if (frame_start) begin
            corner_count <= {15'd0, push_acc};
            overflow     <= push_drop;
        end else begin
            if (push_acc && (corner_count != 16'hFFFF)) corner_count <= corner_count + 1'b1;
            if (push_drop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (20),
        .DEPTH (FIFO_DEPTH)
    ) u_corner_fifo (
        .core_clk (clk),
        .arst_n   (rst),
        .wr_vld   (corner_in),
        .wr_rdy   (fifo_wr_rdy),
        .wr_dat   ({x_in, y_in}),
        .rd_vld   (m_corner_valid),
        .rd_rdy   (m_corner_ready),
        .rd_dat   ({m_corner_x, m_corner_y}),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_fast_frame_sequencer.sv
// Randomized bench for fast_frame_sequencer against a queue-based model of the frame and corner FIFO.
module tb_fast_frame_sequencer;
    localparam int NPIX  = 32;
    localparam int NFL   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_pix_data = '0;
    logic       s_pix_valid = 1'b0;
    logic       corner_in = 1'b0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic       m_corner_ready = 1'b0;
    logic       busy, frame_done, s_pix_ready, fast_ce, m_corner_valid, overflow;
    logic [7:0] fast_data;
    logic [9:0] m_corner_x, m_corner_y;
    logic [15:0] corner_count;

    fast_frame_sequencer #(
        .COL_NUM(8), .ROW_NUM(4), .PIXEL_WIDTH(8), .FLUSH_LINES(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
        .fast_ce(fast_ce), .fast_data(fast_data), .corner_in(corner_in), .x_in(x_in), .y_in(y_in),
        .m_corner_valid(m_corner_valid), .m_corner_ready(m_corner_ready),
        .m_corner_x(m_corner_x), .m_corner_y(m_corner_y),
        .corner_count(corner_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_pulses = 0;
    int          hs_cyc[$];
    int          ce_cyc[$];
    logic [7:0]  ce_dat[$];
    logic [7:0]  exp_pix[$];
    logic [19:0] act_pop[$];
    logic [19:0] exp_pop[$];
    logic [19:0] mdl_fifo[$];
    int          mdl_count = 0;
    bit          mdl_ovf = 1'b0;

    // Log handshakes/pops before the edge, ce/frame_done just after it; model the corner FIFO as a queue.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (s_pix_valid && s_pix_ready) hs_cyc.push_back(cyc);
            if (m_corner_valid && m_corner_ready) act_pop.push_back({m_corner_x, m_corner_y});
            if (m_corner_ready && mdl_fifo.size() > 0) exp_pop.push_back(mdl_fifo.pop_front());
            if (corner_in) begin
                if (mdl_fifo.size() < DEPTH) begin
                    mdl_fifo.push_back({x_in, y_in});
                    if (mdl_count < 65535) mdl_count++;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
        end
        #1;
        if (rst) begin
            if (fast_ce) begin
                ce_cyc.push_back(cyc);
                ce_dat.push_back(fast_data);
            end
            if (frame_done) done_pulses++;
        end
    end

    task automatic clear_logs();
        hs_cyc.delete(); ce_cyc.delete(); ce_dat.delete(); exp_pix.delete();
        act_pop.delete(); exp_pop.delete();
        done_pulses = 0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        mdl_count = 0;
        mdl_ovf   = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int gap_max, output bit timeout);
        logic [7:0] d;
        bit         acc;
        int         w;
        timeout = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                s_pix_valid = 1'b0;
                @(negedge clk);
            end
            d = 8'($urandom);
            s_pix_valid = 1'b1;
            s_pix_data  = d;
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 200) begin
                #4 acc = s_pix_ready;
                @(negedge clk);
                w++;
            end
            if (!acc) begin
                timeout = 1'b1;
                s_pix_valid = 1'b0;
                return;
            end
            exp_pix.push_back(d);
        end
        s_pix_valid = 1'b0;
    endtask

    task automatic wait_done(output bit timeout);
        int w = 0;
        s_pix_valid = 1'b0;
        while (done_pulses == 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        timeout = (done_pulses == 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic push_corner(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        corner_in = 1'b1; x_in = x; y_in = y;
        @(negedge clk);
        corner_in = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #3;
        tests++;
        if ({busy, frame_done, s_pix_ready, fast_ce, m_corner_valid, overflow} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000", {busy, frame_done, s_pix_ready, fast_ce, m_corner_valid, overflow});
        end
        tests++;
        if ({fast_data, m_corner_x, m_corner_y, corner_count} !== 44'd0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {fast_data, m_corner_x, m_corner_y, corner_count});
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit         to1, to2;
        logic [7:0] exp_ce[$];
        clear_logs();
        m_corner_ready = 1'b1;
        do_start();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b want 1", busy); end
        send_pixels(NPIX, 0, to1);
        wait_done(to2);
        exp_ce = exp_pix;
        repeat (NFL) exp_ce.push_back(8'd0);
        tests++;
        if (to1 || to2) begin fails++; $display("FAIL b2b_timeout: got %b%b want 00", to1, to2); end
        tests++;
        if (ce_dat.size() != exp_ce.size()) begin
            fails++; $display("FAIL b2b_ce_count: got %0d want %0d", ce_dat.size(), exp_ce.size());
        end else begin
            for (int i = 0; i < exp_ce.size(); i++) begin
                tests++;
                if (ce_dat[i] !== exp_ce[i]) begin
                    fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ce_dat[i], exp_ce[i]);
                end
            end
            tests++;
            if (hs_cyc.size() != NPIX || hs_cyc[NPIX-1] - hs_cyc[0] != NPIX - 1) begin
                fails++; $display("FAIL b2b_ready_gaps: got %0d handshakes want %0d back-to-back", hs_cyc.size(), NPIX);
            end else begin
                for (int i = 0; i < NPIX; i++) begin
                    tests++;
                    if (ce_cyc[i] != hs_cyc[i]) begin
                        fails++; $display("FAIL b2b_latency[%0d]: ce edge %0d want %0d", i, ce_cyc[i], hs_cyc[i]);
                    end
                end
                tests++;
                if (ce_cyc[NPIX] != hs_cyc[NPIX-1] + 1 || ce_cyc[NPIX+NFL-1] != hs_cyc[NPIX-1] + NFL) begin
                    fails++; $display("FAIL b2b_flush_timing: got %0d..%0d want %0d..%0d", ce_cyc[NPIX],
                        ce_cyc[NPIX+NFL-1], hs_cyc[NPIX-1] + 1, hs_cyc[NPIX-1] + NFL);
                end
            end
        end
        tests++;
        if (done_pulses != 1) begin fails++; $display("FAIL b2b_frame_done: got %0d pulses want 1", done_pulses); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_random_gaps();
        bit         to1, to2;
        int         early;
        logic [7:0] exp_ce[$];
        for (int r = 0; r < 2; r++) begin
            clear_logs();
            m_corner_ready = 1'b1;
            do_start();
            send_pixels(NPIX, 2 + 2 * r, to1);
            wait_done(to2);
            exp_ce = exp_pix;
            repeat (NFL) exp_ce.push_back(8'd0);
            tests++;
            if (to1 || to2) begin fails++; $display("FAIL gaps_timeout: got %b%b want 00", to1, to2); end
            tests++;
            if (ce_dat.size() != exp_ce.size() || hs_cyc.size() != NPIX) begin
                fails++; $display("FAIL gaps_ce_count: got %0d want %0d", ce_dat.size(), exp_ce.size());
            end else begin
                for (int i = 0; i < exp_ce.size(); i++) begin
                    tests++;
                    if (ce_dat[i] !== exp_ce[i]) begin
                        fails++; $display("FAIL gaps_data[%0d]: got %h want %h", i, ce_dat[i], exp_ce[i]);
                    end
                end
                early = 0;
                foreach (ce_cyc[i]) if (ce_cyc[i] <= hs_cyc[NPIX-1]) early++;
                tests++;
                if (early != NPIX) begin
                    fails++; $display("FAIL gaps_flush_early: got %0d ce by last pixel want %0d", early, NPIX);
                end
            end
            tests++;
            if (done_pulses != 1) begin fails++; $display("FAIL gaps_frame_done: got %0d want 1", done_pulses); end
        end
    endtask

    task automatic test_corners();
        bit          to1, to2;
        logic [19:0] c0, c1;
        c0 = {10'd3, 10'd1};
        c1 = {10'd5, 10'd2};
        clear_logs();
        m_corner_ready = 1'b1;
        do_start();
        @(negedge clk); corner_in = 1'b1; x_in = 10'd3; y_in = 10'd1;
        @(negedge clk); x_in = 10'd5; y_in = 10'd2;
        @(negedge clk); corner_in = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (act_pop.size() != 2 || exp_pop.size() != 2) begin
            fails++; $display("FAIL corner_pops: got %0d want 2", act_pop.size());
        end else begin
            tests++;
            if (act_pop[0] !== c0 || act_pop[1] !== c1) begin
                fails++; $display("FAIL corner_order: got %h,%h want %h,%h", act_pop[0], act_pop[1], c0, c1);
            end
            tests++;
            if (act_pop[0] !== exp_pop[0] || act_pop[1] !== exp_pop[1]) begin
                fails++; $display("FAIL corner_model: got %h,%h want %h,%h", act_pop[0], act_pop[1], exp_pop[0], exp_pop[1]);
            end
        end
        tests++;
        if (corner_count !== 16'(mdl_count)) begin fails++; $display("FAIL corner_count: got %0d want %0d", corner_count, mdl_count); end
        tests++;
        if (overflow !== mdl_ovf) begin fails++; $display("FAIL corner_overflow: got %b want %b", overflow, mdl_ovf); end
        send_pixels(NPIX, 1, to1);
        wait_done(to2);
        tests++;
        if (to1 || to2 || done_pulses != 1) begin fails++; $display("FAIL corner_frame_end: got %0d pulses want 1", done_pulses); end
    endtask

    task automatic test_stall();
        bit to1, to2;
        int bad = 0;
        clear_logs();
        m_corner_ready = 1'b0;
        do_start();
        push_corner(10'd7, 10'd0);
        push_corner(10'd9, 10'd3);
        s_pix_valid = 1'b1;
        s_pix_data  = 8'hA5;
        repeat (6) begin
            @(negedge clk);
            if (s_pix_ready !== 1'b0 || fast_ce !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL stall_hold: got %0d active cycles want 0", bad); end
        tests++;
        if (m_corner_valid !== 1'b1 || {m_corner_x, m_corner_y} !== {10'd7, 10'd0}) begin
            fails++; $display("FAIL stall_head: got %b %h want 1 %h", m_corner_valid, {m_corner_x, m_corner_y}, {10'd7, 10'd0});
        end
        m_corner_ready = 1'b1;
        @(negedge clk);
        m_corner_ready = 1'b0;
        tests++;
        if (s_pix_ready !== 1'b1 || {m_corner_x, m_corner_y} !== {10'd9, 10'd3}) begin
            fails++; $display("FAIL stall_release: got rdy=%b head=%h want rdy=1 head=%h", s_pix_ready, {m_corner_x, m_corner_y}, {10'd9, 10'd3});
        end
        @(negedge clk);
        tests++;
        if (fast_ce !== 1'b1 || fast_data !== 8'hA5) begin
            fails++; $display("FAIL stall_first_pix: got ce=%b data=%h want ce=1 data=a5", fast_ce, fast_data);
        end
        exp_pix.push_back(8'hA5);
        s_pix_valid = 1'b0;
        m_corner_ready = 1'b1;
        send_pixels(NPIX - 1, 0, to1);
        wait_done(to2);
        tests++;
        if (to1 || to2 || ce_dat.size() != NPIX + NFL || done_pulses != 1) begin
            fails++; $display("FAIL stall_frame: got %0d ce %0d done want %0d ce 1 done", ce_dat.size(), done_pulses, NPIX + NFL);
        end
        tests++;
        if (act_pop != exp_pop) begin fails++; $display("FAIL stall_pops: got %0d pops want %0d", act_pop.size(), exp_pop.size()); end
    endtask

    task automatic test_full();
        bit to1, to2;
        clear_logs();
        m_corner_ready = 1'b0;
        do_start();
        for (int i = 0; i < DEPTH; i++) push_corner(10'(i + 1), 10'(i + 20));
        @(negedge clk);
        corner_in = 1'b1; x_in = 10'd100; y_in = 10'd200; m_corner_ready = 1'b1;
        @(negedge clk);
        corner_in = 1'b0; m_corner_ready = 1'b0;
        tests++;
        if (overflow !== mdl_ovf || corner_count !== 16'(mdl_count)) begin
            fails++; $display("FAIL full_pushpop: got ovf=%b cnt=%0d want ovf=%b cnt=%0d", overflow, corner_count, mdl_ovf, mdl_count);
        end
        push_corner(10'd300, 10'd301);
        tests++;
        if (overflow !== 1'b1 || mdl_ovf !== 1'b1) begin fails++; $display("FAIL full_overflow: got %b want 1", overflow); end
        tests++;
        if (corner_count !== 16'(mdl_count) || mdl_count != DEPTH + 1) begin
            fails++; $display("FAIL full_count: got %0d want %0d", corner_count, DEPTH + 1);
        end
        m_corner_ready = 1'b1;
        repeat (8) @(negedge clk);
        tests++;
        if (act_pop.size() != DEPTH + 1 || act_pop != exp_pop) begin
            fails++; $display("FAIL full_pops: got %0d pops want %0d", act_pop.size(), DEPTH + 1);
        end else begin
            tests++;
            if (act_pop[DEPTH] !== {10'd100, 10'd200}) begin
                fails++; $display("FAIL full_last: got %h want %h", act_pop[DEPTH], {10'd100, 10'd200});
            end
        end
        send_pixels(NPIX, 0, to1);
        wait_done(to2);
        tests++;
        if (to1 || to2 || overflow !== 1'b1) begin fails++; $display("FAIL full_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_mid();
        bit to1, to2;
        clear_logs();
        m_corner_ready = 1'b1;
        do_start();
        tests++;
        if (overflow !== 1'b0 || corner_count !== 16'd0) begin
            fails++; $display("FAIL start_clear: got ovf=%b cnt=%0d want 0 0", overflow, corner_count);
        end
        send_pixels(10, 0, to1);
        m_corner_ready = 1'b0;
        push_corner(10'd11, 10'd12);
        push_corner(10'd13, 10'd14);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({busy, frame_done, s_pix_ready, fast_ce, m_corner_valid, overflow} !== 6'b0 ||
            {fast_data, m_corner_x, m_corner_y, corner_count} !== 44'd0) begin
            fails++; $display("FAIL midreset_outputs: got %b %h want 0", {busy, frame_done, s_pix_ready, fast_ce, m_corner_valid, overflow},
                {fast_data, m_corner_x, m_corner_y, corner_count});
        end
        mdl_fifo.delete();
        @(negedge clk); rst = 1'b1;
        clear_logs();
        m_corner_ready = 1'b1;
        do_start();
        send_pixels(NPIX, 0, to2);
        wait_done(to1);
        tests++;
        if (to1 || to2 || ce_dat.size() != NPIX + NFL || done_pulses != 1) begin
            fails++; $display("FAIL midreset_frame: got %0d ce %0d done want %0d ce 1 done", ce_dat.size(), done_pulses, NPIX + NFL);
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                tests++;
                if (ce_dat[i] !== exp_pix[i]) begin fails++; $display("FAIL midreset_data[%0d]: got %h want %h", i, ce_dat[i], exp_pix[i]); end
            end
        end
        tests++;
        if (act_pop.size() != 0) begin fails++; $display("FAIL midreset_fifo: got %0d pops want 0", act_pop.size()); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_gaps();
        test_corners();
        test_stall();
        test_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
